// File: rtl/modexp_ctrl_if.sv
// Bus between modexp_ctrl (master) and one external Montgomery multiplier (slave).
//   mont_start   master -> slave   one-cycle request
//   mont_a/b     master -> slave   operands, stable from request until mont_done
//   mont_m       master -> slave   modulus
//   mont_result  slave -> master   a*b*R^-1 mod m, valid while mont_done=1
//   mont_done    slave -> master   one-cycle completion pulse
interface modexp_ctrl_if #(
    parameter int N = 512
);
    logic         mont_start;
    logic [N-1:0] mont_a;
    logic [N-1:0] mont_b;
    logic [N-1:0] mont_m;
    logic [N-1:0] mont_result;
    logic         mont_done;

    modport master (
        output mont_start, mont_a, mont_b, mont_m,
        input  mont_result, mont_done
    );

    modport slave (
        input  mont_start, mont_a, mont_b, mont_m,
        output mont_result, mont_done
    );
endinterface

// File: rtl/modexp_ctrl.sv
// Modular exponentiation sequencer: result = x^e mod m by left-to-right
// square-and-multiply, using one external Montgomery multiplier through the
// modexp_ctrl_if master modport.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start                 request pulse, accepted only in IDLE
//   in_x, in_e, in_m      base, exponent, odd modulus (normal domain)
//   in_r, in_r2           R mod m and R^2 mod m, R = 2^N
//   result                x^e mod m, valid from done, held until next job finishes
//   done                  one-cycle completion pulse
//   busy                  high from accepted start through done
//   mont_ops              Montgomery ops issued for the current/last job
//   mont                  multiplier bus (master)
//
// Build option MODEXP_LZ_SKIP_EN: when defined, the bit walk starts at the
// highest set bit of e, so leading zero bits issue no ops (e=0 goes straight
// to the conversion out of the Montgomery domain). When undefined, every one
// of the E_BITS bits issues a squaring. The result is the same either way.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start
// S_ISSUE  | mont_start high for op_q; operands already on the bus
// S_WAIT   | waiting for mont_done; result captured on that cycle
// S_STEP   | pick next op from op_q / e[i], load operands
// S_FIN    | done pulse, back to IDLE
module modexp_ctrl #(
    parameter int N      = 512,
    parameter int E_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_r,
    input  logic [N-1:0]      in_r2,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              busy,
    output logic [15:0]       mont_ops,
    modexp_ctrl_if.master     mont
);

    localparam int I_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_TOMONT,
        OP_SQR,
        OP_MUL,
        OP_FROMMONT
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [E_BITS-1:0] e_q;
    logic [N-1:0]      r_q;
    logic [N-1:0]      xt_q;
    logic [N-1:0]      acc_q;
    logic [I_W-1:0]    i_q, i_d;
    logic [I_W-1:0]    top_idx;
    logic [N-1:0]      a_d, b_d;

`ifdef MODEXP_LZ_SKIP_EN
    localparam bit LZ_SKIP = 1'b1;

    // Highest set bit of the latched exponent; 0 when e=0 (unused then).
    always_comb begin
        top_idx = '0;
        for (int k = 0; k < E_BITS; k++) begin
            if (e_q[k]) top_idx = I_W'(k);
        end
    end
`else
    localparam bit LZ_SKIP = 1'b0;

    assign top_idx = I_W'(E_BITS - 1);
`endif

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FIN);
    assign mont.mont_start = (state_q == S_ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_TOMONT;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        i_d     = i_q;
        a_d     = mont.mont_a;
        b_d     = mont.mont_b;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    op_d    = OP_TOMONT;
                    a_d     = in_x;
                    b_d     = in_r2;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mont.mont_done) begin
                    state_d = (op_q == OP_FROMMONT) ? S_FIN : S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_ISSUE;
                // Default target is the exit conversion Mont(acc, 1).
                op_d = OP_FROMMONT;
                a_d  = acc_q;
                b_d  = ONE;
                case (op_q)
                    OP_TOMONT: begin
                        if (!(LZ_SKIP && (e_q == '0))) begin
                            op_d = OP_SQR;
                            b_d  = acc_q;
                        end
                    end
                    OP_SQR: begin
                        if (e_q[i_q]) begin
                            op_d = OP_MUL;
                            b_d  = xt_q;
                        end else if (i_q != '0) begin
                            op_d = OP_SQR;
                            b_d  = acc_q;
                            i_d  = i_q - 1'b1;
                        end
                    end
                    OP_MUL: begin
                        if (i_q != '0) begin
                            op_d = OP_SQR;
                            b_d  = acc_q;
                            i_d  = i_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q         <= '0;
            r_q         <= '0;
            xt_q        <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            result      <= '0;
            mont_ops    <= '0;
            mont.mont_a <= '0;
            mont.mont_b <= '0;
            mont.mont_m <= '0;
        end else begin
            mont.mont_a <= a_d;
            mont.mont_b <= b_d;
            i_q         <= i_d;
            if ((state_q == S_IDLE) && start) begin
                e_q         <= in_e;
                r_q         <= in_r;
                mont.mont_m <= in_m;
                mont_ops    <= '0;
            end
            if (state_q == S_ISSUE) begin
                mont_ops <= mont_ops + 16'd1;
            end
            if ((state_q == S_WAIT) && mont.mont_done) begin
                case (op_q)
                    OP_TOMONT: begin
                        xt_q  <= mont.mont_result;
                        acc_q <= r_q;
                        i_q   <= top_idx;
                    end
                    OP_SQR, OP_MUL: begin
                        acc_q <= mont.mont_result;
                    end
                    default: begin
                        result <= mont.mont_result;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;

    localparam int N      = 512;
    localparam int E_BITS = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [N-1:0]      in_x = '0;
    logic [E_BITS-1:0] in_e = '0;
    logic [N-1:0]      in_m = '0;
    logic [N-1:0]      in_r = '0;
    logic [N-1:0]      in_r2 = '0;
    logic [N-1:0]      result;
    logic              done;
    logic              busy;
    logic [15:0]       mont_ops;

    modexp_ctrl_if #(.N(N)) mif ();

    modexp_ctrl #(.N(N), .E_BITS(E_BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_x     (in_x),
        .in_e     (in_e),
        .in_m     (in_m),
        .in_r     (in_r),
        .in_r2    (in_r2),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .mont_ops (mont_ops),
        .mont     (mif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int proto_err = 0;
    int lat_lo = 1;
    int lat_hi = 4;
    bit spur_req = 1'b0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Montgomery product a*b*R^-1 mod m, R = 2^N, m odd.
    function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] m);
        logic [N-1:0]     inv, mp, u;
        logic [2*N+1:0]   t, s, q;
        inv = 1;
        for (int k = 0; k < 10; k++) inv = inv * (2 - m * inv);
        mp = -inv;
        t = a * b;
        u = t[N-1:0] * mp;
        s = t + u * m;
        q = s >> N;
        if (q >= m) q = q - m;
        return q[N-1:0];
    endfunction

    function automatic logic [N-1:0] r_pow(input logic [N-1:0] m, input bit squared);
        logic [2*N:0] big, rem;
        big = '0;
        if (squared) big[2*N] = 1'b1;
        else         big[N]   = 1'b1;
        rem = big % m;
        return rem[N-1:0];
    endfunction

    function automatic logic [N-1:0] modpow(input logic [N-1:0] x, input logic [E_BITS-1:0] e,
                                            input logic [N-1:0] m);
        logic [2*N-1:0] acc;
        acc = (m == 1) ? 0 : 1;
        for (int k = E_BITS - 1; k >= 0; k--) begin
            acc = (acc * acc) % m;
            if (e[k]) acc = (acc * x) % m;
        end
        return acc[N-1:0];
    endfunction

    function automatic int exp_ops(input logic [E_BITS-1:0] e);
        int pop;
        int msb;
        pop = $countones(e);
        msb = -1;
        for (int k = 0; k < E_BITS; k++) if (e[k]) msb = k;
`ifdef MODEXP_LZ_SKIP_EN
        return 2 + (msb + 1) + pop;
`else
        return 2 + E_BITS + pop;
`endif
    endfunction

    function automatic logic [N-1:0] rand_mod();
        logic [N-1:0] m;
        m = rand_wide();
        m[0] = 1'b1;
        m[N-1] = 1'b1;
        return m;
    endfunction

    // ---------------- Montgomery core responder ----------------
    initial begin
        logic [N-1:0] la, lb, lm, lres;
        int  cnt;
        bit  rbusy;
        bit  prev_start;
        la = '0; lb = '0; lm = '0; lres = '0;
        cnt = 0;
        rbusy = 1'b0;
        prev_start = 1'b0;
        mif.mont_done = 1'b0;
        mif.mont_result = '0;
        forever begin
            @(negedge clk);
            mif.mont_done = 1'b0;
            if (reset) begin
                rbusy = 1'b0;
                prev_start = 1'b0;
                continue;
            end
            if (spur_req) begin
                mif.mont_done = 1'b1;
                mif.mont_result = rand_wide();
                spur_req = 1'b0;
            end
            if (rbusy) begin
                if (mif.mont_a !== la || mif.mont_b !== lb || mif.mont_m !== lm) proto_err++;
                cnt--;
                if (cnt == 0) begin
                    mif.mont_done = 1'b1;
                    mif.mont_result = lres;
                    rbusy = 1'b0;
                end
            end
            if (mif.mont_start === 1'b1) begin
                if (prev_start || rbusy) proto_err++;
                la = mif.mont_a;
                lb = mif.mont_b;
                lm = mif.mont_m;
                lres = mont_mul(la, lb, lm);
                cnt = $urandom_range(lat_hi, lat_lo);
                rbusy = 1'b1;
            end
            prev_start = (mif.mont_start === 1'b1);
        end
    end

    // ---------------- job driver ----------------
    task automatic run_job(input logic [N-1:0] x, input logic [E_BITS-1:0] e,
                           input logic [N-1:0] m, output logic [N-1:0] res,
                           output int ops, output int ndone, output bit busy_hi,
                           output bit busy_after, output bit timed_out);
        @(negedge clk);
        in_x = x;
        in_e = e;
        in_m = m;
        in_r = r_pow(m, 1'b0);
        in_r2 = r_pow(m, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_hi = busy;
        ndone = 0;
        res = '0;
        ops = 0;
        busy_after = 1'b1;
        timed_out = 1'b1;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                res = result;
                ops = int'(mont_ops);
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) begin
            @(negedge clk);
            busy_after = busy;
            if (done === 1'b1) ndone++;
            repeat (2) begin
                @(negedge clk);
                if (done === 1'b1) ndone++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %0h expected 0", result); end
        n_cmp++;
        if ({done, busy, mif.mont_start} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got done/busy/start=%b expected 000", {done, busy, mif.mont_start});
        end
        n_cmp++;
        if (mont_ops !== 16'd0) begin n_bad++; $display("FAIL reset_ops: got %0d expected 0", mont_ops); end
        n_cmp++;
        if ((mif.mont_a | mif.mont_b | mif.mont_m) !== '0) begin
            n_bad++; $display("FAIL reset_operands: got nonzero operand bus expected 0");
        end
    endtask

    task automatic test_known();
        logic [N-1:0] res;
        int ops, nd, p0;
        bit bh, ba, to;
        p0 = proto_err;
        lat_lo = 1; lat_hi = 8;
        run_job(N'(4), 16'd13, N'(497), res, ops, nd, bh, ba, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL known_timeout: got no done expected done"); end
        n_cmp++;
        if (res !== N'(445)) begin n_bad++; $display("FAIL known_result: got %0d expected 445", res); end
        n_cmp++;
        if (nd != 1) begin n_bad++; $display("FAIL known_done_pulses: got %0d expected 1", nd); end
        n_cmp++;
        if (bh !== 1'b1) begin n_bad++; $display("FAIL known_busy_start: got %0b expected 1", bh); end
        n_cmp++;
        if (ba !== 1'b0) begin n_bad++; $display("FAIL known_busy_after: got %0b expected 0", ba); end
        n_cmp++;
        if (ops != exp_ops(16'd13)) begin n_bad++; $display("FAIL known_ops: got %0d expected %0d", ops, exp_ops(16'd13)); end
        n_cmp++;
        if (proto_err != p0) begin n_bad++; $display("FAIL known_protocol: got %0d errors expected 0", proto_err - p0); end
    endtask

    task automatic test_e5();
        logic [N-1:0] res;
        int ops, nd, want_ops;
        bit bh, ba, to;
`ifdef MODEXP_LZ_SKIP_EN
        want_ops = 7;
`else
        want_ops = 20;
`endif
        lat_lo = 1; lat_hi = 6;
        run_job(N'(3), 16'h0005, N'(1000003), res, ops, nd, bh, ba, to);
        n_cmp++;
        if (to || res !== N'(243)) begin n_bad++; $display("FAIL e5_result: got %0d expected 243", res); end
        n_cmp++;
        if (ops != want_ops) begin n_bad++; $display("FAIL e5_ops: got %0d expected %0d", ops, want_ops); end
    endtask

    task automatic test_spurious_done();
        int seen_busy, seen_start;
        seen_busy = 0;
        seen_start = 0;
        @(negedge clk);
        spur_req = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy++;
            if (mif.mont_start === 1'b1) seen_start++;
        end
        n_cmp++;
        if (seen_busy + seen_start != 0) begin
            n_bad++; $display("FAIL spurious_activity: got busy=%0d start=%0d cycles expected 0", seen_busy, seen_start);
        end
        n_cmp++;
        if (result !== N'(243)) begin n_bad++; $display("FAIL spurious_result: got %0d expected 243", result); end
        n_cmp++;
        if (int'(mont_ops) != exp_ops(16'h0005)) begin
            n_bad++; $display("FAIL spurious_ops: got %0d expected %0d", mont_ops, exp_ops(16'h0005));
        end
    endtask

    task automatic test_e_edges();
        logic [N-1:0] res, m, x;
        int ops, nd;
        bit bh, ba, to;
        lat_lo = 1; lat_hi = 5;
        m = rand_mod();
        x = rand_wide() % m;
        run_job(x, 16'd0, m, res, ops, nd, bh, ba, to);
        n_cmp++;
        if (to || res !== N'(1)) begin n_bad++; $display("FAIL e0_result: got %0h expected 1", res); end
        n_cmp++;
        if (ops != exp_ops(16'd0)) begin n_bad++; $display("FAIL e0_ops: got %0d expected %0d", ops, exp_ops(16'd0)); end
        lat_lo = 600; lat_hi = 600;
        run_job(N'(123), 16'd1, m, res, ops, nd, bh, ba, to);
        n_cmp++;
        if (to || res !== N'(123)) begin n_bad++; $display("FAIL e1_slow_result: got %0h expected 7b", res); end
        n_cmp++;
        if (nd != 1 || ba !== 1'b0) begin n_bad++; $display("FAIL e1_slow_done: got pulses=%0d busy_after=%0b expected 1/0", nd, ba); end
    endtask

    task automatic test_start_ignored();
        logic [N-1:0] m, x, want, res;
        logic [E_BITS-1:0] e;
        int ops, extra, p0;
        bit found, ba;
        p0 = proto_err;
        lat_lo = 3; lat_hi = 6;
        m = rand_mod();
        x = rand_wide() % m;
        e = E_BITS'($urandom_range(16'hffff, 16'h8001));
        want = modpow(x, e, m);
        @(negedge clk);
        in_x = x; in_e = e; in_m = m;
        in_r = r_pow(m, 1'b0); in_r2 = r_pow(m, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (mont_ops >= 16'd2 && mif.mont_start === 1'b0) begin found = 1'b1; break; end
        end
        // pulse start mid-WAIT with unrelated operands
        in_x = rand_wide(); in_e = 16'h0003; in_m = rand_mod();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res = '0; ops = 0; ba = 1'b1; extra = 0;
        found = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1'b1; break; end
        end
        if (found) begin
            res = result;
            ops = int'(mont_ops);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ba = busy;
            repeat (6) begin
                @(negedge clk);
                if (busy === 1'b1 || mif.mont_start === 1'b1) extra++;
            end
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL ignore_timeout: got no done expected done"); end
        n_cmp++;
        if (res !== want) begin n_bad++; $display("FAIL ignore_result: got %0h expected %0h", res, want); end
        n_cmp++;
        if (ops != exp_ops(e)) begin n_bad++; $display("FAIL ignore_ops: got %0d expected %0d", ops, exp_ops(e)); end
        n_cmp++;
        if (ba !== 1'b0 || extra != 0) begin
            n_bad++; $display("FAIL ignore_fin_start: got busy_after=%0b active_cycles=%0d expected 0/0", ba, extra);
        end
        n_cmp++;
        if (proto_err != p0) begin n_bad++; $display("FAIL ignore_protocol: got %0d errors expected 0", proto_err - p0); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] m, x, want, res;
        logic [E_BITS-1:0] e;
        int ops, nd;
        bit bh, ba, to, found;
        lat_lo = 50; lat_hi = 50;
        m = rand_mod();
        x = rand_wide() % m;
        @(negedge clk);
        in_x = x; in_e = 16'hbeef; in_m = m;
        in_r = r_pow(m, 1'b0); in_r2 = r_pow(m, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (mont_ops == 16'd2 && mif.mont_start === 1'b0) begin found = 1'b1; break; end
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL rstmid_reach_sqr: got no SQR wait expected one"); end
        n_cmp++;
        if ({busy, done, mif.mont_start} !== 3'b000 || mont_ops !== 16'd0) begin
            n_bad++; $display("FAIL rstmid_ctrl: got busy/done/start=%b ops=%0d expected 000/0", {busy, done, mif.mont_start}, mont_ops);
        end
        n_cmp++;
        if ((result | mif.mont_a | mif.mont_b | mif.mont_m) !== '0) begin
            n_bad++; $display("FAIL rstmid_data: got nonzero result/operands expected 0");
        end
        @(negedge clk);
        #1 reset = 1'b0;
        lat_lo = 1; lat_hi = 4;
        e = E_BITS'($urandom);
        want = modpow(x, e, m);
        run_job(x, e, m, res, ops, nd, bh, ba, to);
        n_cmp++;
        if (to || res !== want) begin n_bad++; $display("FAIL rstmid_fresh_result: got %0h expected %0h", res, want); end
        n_cmp++;
        if (ops != exp_ops(e) || nd != 1) begin
            n_bad++; $display("FAIL rstmid_fresh_ops: got ops=%0d pulses=%0d expected %0d/1", ops, nd, exp_ops(e));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m, x, want, res;
        logic [E_BITS-1:0] e;
        int ops, nd, p0;
        bit bh, ba, to;
        p0 = proto_err;
        lat_lo = 1; lat_hi = 3;
        for (int j = 0; j < 200; j++) begin
            m = rand_mod();
            x = rand_wide() % m;
            e = E_BITS'($urandom);
            want = modpow(x, e, m);
            run_job(x, e, m, res, ops, nd, bh, ba, to);
            n_cmp++;
            if (to || res !== want) begin
                n_bad++; $display("FAIL rand_result[%0d]: got %0h expected %0h", j, res, want);
            end
            n_cmp++;
            if (ops != exp_ops(e) || nd != 1) begin
                n_bad++; $display("FAIL rand_ops[%0d]: got ops=%0d pulses=%0d expected %0d/1", j, ops, nd, exp_ops(e));
            end
        end
        n_cmp++;
        if (proto_err != p0) begin n_bad++; $display("FAIL rand_protocol: got %0d errors expected 0", proto_err - p0); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_known();
        test_e5();
        test_spurious_done();
        test_e_edges();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
